// File: rtl/ser_pkg.sv
// Shared FSM state and bit-order constants for the serial deserializer.
package ser_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/deser_hold.sv
// Valid/ready output register for completed words, with sticky overrun on drop.
module deser_hold #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             q_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             overrun
);

  logic accept;
  logic drop;

  // A word fits if the slot is empty or being drained this same cycle.
  assign accept = load & (~q_valid | q_ready);
  assign drop   = load & q_valid & ~q_ready;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        q       <= d;
        q_valid <= 1'b1;
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: framed by sync, per-frame bit order, valid/ready output.
module serial_deserializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sin,
  input  logic             sync,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             load;
  logic [WIDTH-1:0] shifted;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b,
                                                input logic d);
    if (d == DIR_LEFT) begin
      return {cur[WIDTH-2:0], b};
    end
    return {b, cur[WIDTH-1:1]};
  endfunction

  assign shifted = shift_in(sh_q, sin, dir_q);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    load    = 1'b0;
    if (en) begin
      if (sync) begin
        // Sync always (re)starts a frame; any partial word is silently discarded.
        dir_d   = dir;
        sh_d    = shift_in(sh_q, sin, dir);
        cnt_d   = CW'(1);
        state_d = S_RECV;
      end else if (state_q == S_RECV) begin
        sh_d = shifted;
        if (cnt_q == CW'(WIDTH - 1)) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign busy = (state_q == S_RECV);

  deser_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .clr_n  (clr_n),
    .load   (load),
    .d      (shifted),
    .q_ready(q_ready),
    .ovr_clr(ovr_clr),
    .q      (q),
    .q_valid(q_valid),
    .overrun(overrun)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized + directed bench for serial_deserializer with a bit-queue reference model.
module tb_serial_deserializer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         en = 1'b0;
  logic         sin = 1'b0;
  logic         sync = 1'b0;
  logic         dir = 1'b0;
  logic         q_ready = 1'b0;
  logic         ovr_clr = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_busy = 1'b0;
  bit           m_dir = 1'b0;
  bit           m_frame[$];
  bit           m_valid = 1'b0;
  bit           m_ovr = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] exp_q[$];

  bit           prev_valid = 1'b0;
  bit           prev_ready = 1'b0;
  bit           done = 1'b0;

  serial_deserializer #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .en     (en),
    .sin    (sin),
    .sync   (sync),
    .dir    (dir),
    .q      (q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .busy   (busy),
    .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // First bit received goes to bit 0 (dir=0) or bit W-1 (dir=1).
  function automatic logic [W-1:0] assemble(input bit bits[$], input bit d);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (d) w[W-1-i] = bits[i];
      else   w[i] = bits[i];
    end
    return w;
  endfunction

  task automatic model_edge();
    bit complete;
    bit dropped;
    logic [W-1:0] w;
    if (!clr_n) begin
      m_busy = 0; m_dir = 0; m_frame.delete();
      m_valid = 0; m_ovr = 0; m_q = '0;
      return;
    end
    complete = m_busy && en && !sync && (m_frame.size() == W - 1);
    dropped  = 0;
    if (complete) begin
      m_frame.push_back(sin);
      w = assemble(m_frame, m_dir);
      if (!m_valid || q_ready) begin
        m_q = w; m_valid = 1; exp_q.push_back(w);
      end else begin
        dropped = 1; m_ovr = 1;
      end
      m_frame.delete();
      m_busy = 0;
    end else begin
      if (m_valid && q_ready) m_valid = 0;
      if (en && sync) begin
        m_frame.delete(); m_frame.push_back(sin); m_dir = dir; m_busy = 1;
      end else if (en && m_busy) begin
        m_frame.push_back(sin);
      end
    end
    if (!dropped && ovr_clr) m_ovr = 0;
  endtask

  task automatic step(input bit e, input bit s, input bit sy, input bit d, input bit r,
                      input bit oc, input bit cn);
    en = e; sin = s; sync = sy; dir = d; q_ready = r; ovr_clr = oc; clr_n = cn;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, r, 0, 1);
  endtask

  // bits[i] is the i-th bit sent; optional gaps and dir toggling after the sync bit.
  task automatic frame(input logic [W-1:0] bits, input bit d, input bit r, input bit r_last,
                       input bit gap, input bit toggle);
    for (int i = 0; i < W; i++) begin
      step(1, bits[i], i == 0, d ^ (toggle && i > 0 && i[0]), (i == W - 1) ? r_last : r, 0, 1);
      if (gap && i != W - 1) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, r, 0, 1);
    end
  endtask

  // Per-cycle status checks plus scoreboard pop on every newly presented word.
  always @(negedge clk) begin
    if (!done) begin
      check("busy", busy, m_busy);
      check("q_valid", q_valid, m_valid);
      check("overrun", overrun, m_ovr);
      check("q_hold", q, m_q);
      if (q_valid && (!prev_valid || prev_ready)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 1, 0);
        end else begin
          check("sb_word", q, exp_q.pop_front());
        end
      end
      prev_valid = q_valid;
      prev_ready = q_ready;
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0);
    // 1. right-shift frame 1,0,1,1 -> 1101
    frame(4'b1101, 0, 0, 0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    // 2. left-shift with dir toggling after sync -> 1011
    frame(4'b1101, 1, 0, 0, 0, 1);
    idle(2, 0);
    idle(1, 1);
    // 3. A accepted on the edge B completes
    frame(4'b0110, 0, 0, 0, 0, 0);
    idle(1, 0);
    frame(4'b1001, 0, 0, 1, 0, 0);
    idle(2, 0);
    idle(1, 1);
    // 4. overrun, then ovr_clr
    frame(4'b0011, 0, 0, 0, 0, 0);
    frame(4'b1111, 1, 0, 0, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(1, 1);
    // 5. resync after 2 bits, then 0,0,0,1
    step(1, 1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    frame(4'b1000, 0, 0, 0, 0, 0);
    idle(2, 0);
    idle(1, 1);
    // 6. reset mid-frame, unsynced bits ignored
    step(1, 1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 1);
    frame(4'b0101, 1, 1, 1, 0, 0);
    idle(2, 1);
    // 7. gaps
    frame(4'b1101, 0, 0, 0, 1, 0);
    idle(2, 1);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
           $urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) != 0);
    end
    idle(4, 1);
    @(negedge clk);
    #1;
    done = 1;
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
